// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: turns button presses and hit/miss pulses into game states.
// It also drives the graphics freeze control, the remaining-ball count and the BCD score.
module pong_game_ctrl #(
    parameter int unsigned BALLS       = 3,
    parameter int unsigned WAIT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [1:0] ball_left,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        StNewGame = 2'b00,
        StPlay    = 2'b01,
        StNewBall = 2'b10,
        StOver    = 2'b11
    } state_e;

    localparam logic [1:0] BallsInit = 2'(BALLS - 1);
    localparam logic [7:0] WaitLoad  = 8'(WAIT_FRAMES);

    state_e     state_q, state_d;
    logic       still_q, still_d;
    logic [1:0] ball_q, ball_d;
    logic [7:0] score_q, score_d;
    logic [7:0] timer_q, timer_d;
    logic       timer_done;
    logic       btn_press;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = val[7:4];
        units = val[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    assign timer_done = (timer_q == 8'd0);
    assign btn_press  = (btn != 2'b00);

    always_comb begin
        state_d = state_q;
        still_d = still_q;
        ball_d  = ball_q;
        score_d = score_q;
        timer_d = timer_q;

        if (refr_tick && !timer_done) begin
            timer_d = timer_q - 8'd1;
        end

        unique case (state_q)
            StNewGame: begin
                if (btn_press) begin
                    state_d = StPlay;
                    still_d = 1'b0;
                    score_d = 8'h00;
                    ball_d  = BallsInit;
                end
            end
            StPlay: begin
                if (hit) begin
                    score_d = bcd_inc(score_q);
                end
                // The timer load overrides any refr_tick on the same edge.
                if (miss) begin
                    still_d = 1'b1;
                    timer_d = WaitLoad;
                    if (ball_q == 2'd0) begin
                        state_d = StOver;
                    end else begin
                        state_d = StNewBall;
                        ball_d  = ball_q - 2'd1;
                    end
                end
            end
            StNewBall: begin
                if (timer_done && btn_press) begin
                    state_d = StPlay;
                    still_d = 1'b0;
                end
            end
            StOver: begin
                if (timer_done) begin
                    state_d = StNewGame;
                    still_d = 1'b1;
                end
            end
            default: begin
                state_d = StNewGame;
                still_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StNewGame;
            still_q <= 1'b1;
            ball_q  <= BallsInit;
            score_q <= 8'h00;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            still_q <= still_d;
            ball_q  <= ball_d;
            score_q <= score_d;
            timer_q <= timer_d;
        end
    end

    assign game_state = state_q;
    assign gra_still  = still_q;
    assign ball_left  = ball_q;
    assign score      = score_q;

endmodule
